stats_tracker: RTL and testbench

Collects per-round results from the game controller during play, then computes summary statistics and cycles them onto the letter digit (HEX2) and two-digit decimal display (HEX0/HEX1) once the game ends. It sits between the round-sequencing logic and the display decoders. It is the producer of the `statsLetter` / `statsDisplay` pair consumed by the hex and decimal display stages.

---
 rtl/stats_tracker.sv | 259 +++++++++++++++++++++++++
 tb/tb_stats_tracker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stats_tracker.sv
// stats_tracker: accumulates per-round results during play, then divides out the
// average and cycles correct / errors / best / avg onto the letter and decimal displays.
module stats_tracker #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int DWELL_SEC = 2,
   parameter int TIME_W    = 6
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              new_game,
   input  logic              round_done,
   input  logic              round_ok,
   input  logic [TIME_W-1:0] round_time,
   input  logic              game_over,
   output logic [3:0]        stats_letter,
   output logic [7:0]        stats_value,
   output logic              stats_valid
);

   localparam int DWELL_CYC = CLK_HZ * DWELL_SEC;
   localparam int DW_W      = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);
   localparam logic [3:0]  DIV_STEPS = 4'd12;
   localparam logic [6:0]  CNT_MAX   = 7'd99;
   localparam logic [11:0] SUM_MAX   = 12'hFFF;
   localparam logic [3:0]  LTR_C = 4'hC;
   localparam logic [3:0]  LTR_E = 4'hE;
   localparam logic [3:0]  LTR_B = 4'hB;
   localparam logic [3:0]  LTR_A = 4'hA;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_DIVIDE  = 2'd1,
      ST_SHOW    = 2'd2
   } state_t;

   function automatic logic [6:0] sat_inc(input logic [6:0] v);
      logic [6:0] r;
      if (v >= CNT_MAX) r = CNT_MAX;
      else              r = v + 7'd1;
      return r;
   endfunction

   function automatic logic [7:0] clamp99(input logic [11:0] v);
      logic [7:0] r;
      if (v > 12'd99) r = 8'd99;
      else            r = v[7:0];
      return r;
   endfunction

   function automatic logic [3:0] letter_of(input logic [1:0] sel);
      logic [3:0] r;
      case (sel)
         2'd0:    r = LTR_C;
         2'd1:    r = LTR_E;
         2'd2:    r = LTR_B;
         2'd3:    r = LTR_A;
         default: r = LTR_C;
      endcase
      return r;
   endfunction

   state_t state_r, state_next_s;

   logic [6:0]        correct_r, errors_r, rounds_r;
   logic [11:0]       sum_r;
   logic [TIME_W-1:0] best_r;
   logic [6:0]        correct_next_s, errors_next_s, rounds_next_s;
   logic [11:0]       sum_next_s;
   logic [TIME_W-1:0] best_next_s;
   logic [12:0]       sum_wide_s;

   logic [11:0] dvd_r, quot_r;
   logic [6:0]  rem_r;
   logic [3:0]  div_cnt_r;
   logic [7:0]  avg_r;
   logic [7:0]  trial_s;
   logic [6:0]  diff_s;
   logic        trial_ge_s, div_done_s;

   logic [DW_W-1:0] dwell_r, dwell_next_s;
   logic [1:0]      sel_r, sel_next_s;
   logic            show_next_s;
   logic [3:0]      letter_next_s;
   logic [7:0]      value_next_s;
   logic [3:0]      stats_letter_r;
   logic [7:0]      stats_value_r;
   logic            stats_valid_r;

   assign div_done_s = (div_cnt_r == DIV_STEPS);

   // State register
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state_r <= ST_COLLECT;
      else       state_r <= state_next_s;
   end

   // Next-state logic; new_game overrides everything
   always_comb begin
      state_next_s = state_r;
      if (new_game) begin
         state_next_s = ST_COLLECT;
      end else begin
         case (state_r)
            ST_COLLECT: if (game_over)  state_next_s = ST_DIVIDE; else state_next_s = ST_COLLECT;
            ST_DIVIDE:  if (div_done_s) state_next_s = ST_SHOW;   else state_next_s = ST_DIVIDE;
            ST_SHOW:    state_next_s = ST_SHOW;
            default:    state_next_s = ST_COLLECT;
         endcase
      end
   end

   // Round accumulation; a round landing with game_over is folded in before the divide
   always_comb begin
      correct_next_s = correct_r;
      errors_next_s  = errors_r;
      rounds_next_s  = rounds_r;
      sum_next_s     = sum_r;
      best_next_s    = best_r;
      sum_wide_s     = {1'b0, sum_r} + 13'(round_time);
      if (state_r == ST_COLLECT && round_done) begin
         rounds_next_s = sat_inc(rounds_r);
         if (sum_wide_s[12]) sum_next_s = SUM_MAX;
         else                sum_next_s = sum_wide_s[11:0];
         if (round_ok) begin
            correct_next_s = sat_inc(correct_r);
            if (round_time < best_r) best_next_s = round_time;
            else                     best_next_s = best_r;
         end else begin
            errors_next_s = sat_inc(errors_r);
         end
      end else begin
         sum_next_s = sum_r;
      end
   end

   // Statistic registers
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         correct_r <= 7'd0;
         errors_r  <= 7'd0;
         rounds_r  <= 7'd0;
         sum_r     <= 12'd0;
         best_r    <= {TIME_W{1'b1}};
      end else if (new_game) begin
         correct_r <= 7'd0;
         errors_r  <= 7'd0;
         rounds_r  <= 7'd0;
         sum_r     <= 12'd0;
         best_r    <= {TIME_W{1'b1}};
      end else begin
         correct_r <= correct_next_s;
         errors_r  <= errors_next_s;
         rounds_r  <= rounds_next_s;
         sum_r     <= sum_next_s;
         best_r    <= best_next_s;
      end
   end

   // Partial remainder never exceeds 98, so a 7-bit difference is exact
   assign trial_s    = {rem_r, dvd_r[11]};
   assign trial_ge_s = (trial_s >= {1'b0, rounds_r});
   assign diff_s     = trial_s[6:0] - rounds_r;

   // Restoring divider: one quotient bit per cycle, avg latched on the last cycle
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         dvd_r     <= 12'd0;
         quot_r    <= 12'd0;
         rem_r     <= 7'd0;
         div_cnt_r <= 4'd0;
         avg_r     <= 8'd0;
      end else if (new_game) begin
         dvd_r     <= 12'd0;
         quot_r    <= 12'd0;
         rem_r     <= 7'd0;
         div_cnt_r <= 4'd0;
         avg_r     <= 8'd0;
      end else if (state_r == ST_COLLECT && game_over) begin
         dvd_r     <= sum_next_s;
         quot_r    <= 12'd0;
         rem_r     <= 7'd0;
         div_cnt_r <= 4'd0;
      end else if (state_r == ST_DIVIDE && !div_done_s) begin
         dvd_r     <= {dvd_r[10:0], 1'b0};
         quot_r    <= {quot_r[10:0], trial_ge_s};
         rem_r     <= trial_ge_s ? diff_s : trial_s[6:0];
         div_cnt_r <= div_cnt_r + 4'd1;
      end else if (state_r == ST_DIVIDE && div_done_s) begin
         avg_r     <= (rounds_r == 7'd0) ? 8'd0 : clamp99(quot_r);
      end else begin
         avg_r     <= avg_r;
      end
   end

   // Dwell timer and display selector; both sit at zero outside SHOW
   always_comb begin
      dwell_next_s = dwell_r;
      sel_next_s   = sel_r;
      if (new_game) begin
         dwell_next_s = {DW_W{1'b0}};
         sel_next_s   = 2'd0;
      end else if (state_r == ST_SHOW) begin
         if (dwell_r == DWELL_LAST) begin
            dwell_next_s = {DW_W{1'b0}};
            sel_next_s   = sel_r + 2'd1;
         end else begin
            dwell_next_s = dwell_r + {{(DW_W-1){1'b0}}, 1'b1};
            sel_next_s   = sel_r;
         end
      end else begin
         dwell_next_s = {DW_W{1'b0}};
         sel_next_s   = 2'd0;
      end
   end

   // Output values derived from the next selector so letter and value never skew
   always_comb begin
      show_next_s   = !new_game &&
                      ((state_r == ST_DIVIDE && div_done_s) || state_r == ST_SHOW);
      letter_next_s = 4'd0;
      value_next_s  = 8'd0;
      if (show_next_s) begin
         letter_next_s = letter_of(sel_next_s);
         case (sel_next_s)
            2'd0:    value_next_s = {1'b0, correct_r};
            2'd1:    value_next_s = {1'b0, errors_r};
            2'd2:    value_next_s = (correct_r == 7'd0) ? 8'd0 : clamp99(12'(best_r));
            2'd3:    value_next_s = avg_r;
            default: value_next_s = 8'd0;
         endcase
      end else begin
         letter_next_s = 4'd0;
         value_next_s  = 8'd0;
      end
   end

   // Display timing and registered outputs
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         dwell_r        <= {DW_W{1'b0}};
         sel_r          <= 2'd0;
         stats_letter_r <= 4'd0;
         stats_value_r  <= 8'd0;
         stats_valid_r  <= 1'b0;
      end else begin
         dwell_r        <= dwell_next_s;
         sel_r          <= sel_next_s;
         stats_letter_r <= letter_next_s;
         stats_value_r  <= value_next_s;
         stats_valid_r  <= show_next_s;
      end
   end

   assign stats_letter = stats_letter_r;
   assign stats_value  = stats_value_r;
   assign stats_valid  = stats_valid_r;

endmodule

// File: tb/tb_stats_tracker.sv
// Scoreboard bench for stats_tracker: a behavioural model queues the expected
// display sequence at game_over; entries are popped and checked as the DUT shows them.
module tb_stats_tracker;

   localparam int TW = 6;

   logic          clk = 1'b0;
   logic          reset, new_game, round_done, round_ok, game_over;
   logic [TW-1:0] round_time;
   logic [3:0]    stats_letter;
   logic [7:0]    stats_value;
   logic          stats_valid;

   int n_vec = 0;
   int n_err = 0;
   int m_correct, m_errors, m_rounds, m_sum, m_best;

   typedef struct {
      logic [3:0] ltr;
      logic [7:0] val;
   } exp_t;
   exp_t sb_q[$];

   stats_tracker #(.CLK_HZ(10), .DWELL_SEC(1), .TIME_W(TW)) dut (
      .CLOCK_50     (clk),
      .reset        (reset),
      .new_game     (new_game),
      .round_done   (round_done),
      .round_ok     (round_ok),
      .round_time   (round_time),
      .game_over    (game_over),
      .stats_letter (stats_letter),
      .stats_value  (stats_value),
      .stats_valid  (stats_valid)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_correct = 0; m_errors = 0; m_rounds = 0; m_sum = 0; m_best = 63;
      sb_q.delete();
   endtask

   task automatic model_round(input bit ok, input int t);
      m_rounds = (m_rounds < 99) ? m_rounds + 1 : 99;
      m_sum    = (m_sum + t > 4095) ? 4095 : m_sum + t;
      if (ok) begin
         m_correct = (m_correct < 99) ? m_correct + 1 : 99;
         if (t < m_best) m_best = t;
      end else begin
         m_errors = (m_errors < 99) ? m_errors + 1 : 99;
      end
   endtask

   task automatic push_expected();
      exp_t e;
      int avg, bval;
      bval = (m_correct == 0) ? 0 : m_best;
      avg  = (m_rounds == 0) ? 0 : m_sum / m_rounds;
      if (avg > 99) avg = 99;
      e.ltr = 4'hC; e.val = 8'(m_correct); sb_q.push_back(e);
      e.ltr = 4'hE; e.val = 8'(m_errors);  sb_q.push_back(e);
      e.ltr = 4'hB; e.val = 8'(bval);      sb_q.push_back(e);
      e.ltr = 4'hA; e.val = 8'(avg);       sb_q.push_back(e);
      e.ltr = 4'hC; e.val = 8'(m_correct); sb_q.push_back(e);
   endtask

   task automatic pulse_new_game();
      @(negedge clk);
      new_game = 1'b1;
      model_clear();
      @(negedge clk);
      new_game = 1'b0;
   endtask

   task automatic play_round(input bit ok, input int t);
      @(negedge clk);
      round_done = 1'b1; round_ok = ok; round_time = TW'(t);
      model_round(ok, t);
      @(negedge clk);
      round_done = 1'b0;
   endtask

   // game_over pulse, valid latency check, then the scoreboard-driven display walk
   task automatic finish_game(input bit with_rnd, input bit ok, input int t,
                              input bit inject, input string name);
      exp_t e;
      bit bad;
      int first_hi;
      logic [3:0] obs_l;
      logic [7:0] obs_v;
      logic obs_vld;
      @(negedge clk);
      game_over = 1'b1;
      if (with_rnd) begin
         round_done = 1'b1; round_ok = ok; round_time = TW'(t);
         model_round(ok, t);
      end
      push_expected();
      @(negedge clk);
      game_over = 1'b0; round_done = 1'b0;
      first_hi = 0;
      for (int k = 1; k <= 13; k++) begin
         if (inject && k == 5) begin
            round_done = 1'b1; round_ok = 1'b1; round_time = TW'(1); game_over = 1'b1;
         end
         @(negedge clk);
         round_done = 1'b0; game_over = 1'b0;
         if (first_hi == 0 && stats_valid === 1'b1) first_hi = k;
      end
      n_vec++;
      if (first_hi !== 13) begin
         n_err++;
         $display("FAIL %s_valid_latency: valid first high after %0d edges, required 13", name, first_hi);
      end
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         bad = 1'b0;
         obs_l = 4'd0; obs_v = 8'd0; obs_vld = 1'b0;
         for (int c = 0; c < 10; c++) begin
            if (!bad && (stats_valid !== 1'b1 || stats_letter !== e.ltr || stats_value !== e.val)) begin
               bad = 1'b1; obs_l = stats_letter; obs_v = stats_value; obs_vld = stats_valid;
            end
            @(negedge clk);
         end
         n_vec++;
         if (bad) begin
            n_err++;
            $display("FAIL %s_show_%h: got valid=%0b letter=%h value=%0d, required valid=1 letter=%h value=%0d for 10 cycles",
                     name, e.ltr, obs_vld, obs_l, obs_v, e.ltr, e.val);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if (stats_valid !== 1'b0 || stats_letter !== 4'd0 || stats_value !== 8'd0) begin
         n_err++;
         $display("FAIL reset_outputs: valid=%0b letter=%h value=%0d, required 0/0/0", stats_valid, stats_letter, stats_value);
      end
      reset = 1'b0;
      model_clear();
      play_round(1'b1, 5);
      n_vec++;
      if (stats_valid !== 1'b0 || stats_letter !== 4'd0 || stats_value !== 8'd0) begin
         n_err++;
         $display("FAIL collect_outputs: valid=%0b letter=%h value=%0d, required 0/0/0", stats_valid, stats_letter, stats_value);
      end
   endtask

   task automatic test_basic();
      pulse_new_game();
      play_round(1'b1, 5);
      play_round(1'b1, 3);
      play_round(1'b0, 10);
      play_round(1'b1, 7);
      finish_game(1'b0, 1'b0, 0, 1'b1, "basic");
   endtask

   task automatic test_no_rounds();
      pulse_new_game();
      finish_game(1'b0, 1'b0, 0, 1'b0, "no_rounds");
   endtask

   task automatic test_same_cycle();
      pulse_new_game();
      play_round(1'b1, 8);
      finish_game(1'b1, 1'b1, 4, 1'b0, "same_cycle");
   endtask

   task automatic test_err_sat();
      pulse_new_game();
      for (int i = 0; i < 105; i++) play_round(1'b0, 63);
      finish_game(1'b0, 1'b0, 0, 1'b0, "err_sat");
   endtask

   task automatic test_ok_sat();
      pulse_new_game();
      for (int i = 0; i < 100; i++) play_round(1'b1, 40);
      finish_game(1'b0, 1'b0, 0, 1'b0, "ok_sat");
   endtask

   task automatic test_new_game_reset();
      pulse_new_game();
      play_round(1'b1, 9);
      finish_game(1'b0, 1'b0, 0, 1'b0, "pre_clear");
      pulse_new_game();
      n_vec++;
      if (stats_valid !== 1'b0 || stats_letter !== 4'd0 || stats_value !== 8'd0) begin
         n_err++;
         $display("FAIL new_game_in_show: valid=%0b letter=%h value=%0d, required 0/0/0", stats_valid, stats_letter, stats_value);
      end
      play_round(1'b1, 2);
      play_round(1'b0, 4);
      @(negedge clk);
      game_over = 1'b1;
      @(negedge clk);
      game_over = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if (stats_valid !== 1'b0 || stats_letter !== 4'd0 || stats_value !== 8'd0) begin
         n_err++;
         $display("FAIL reset_in_divide: valid=%0b letter=%h value=%0d, required 0/0/0", stats_valid, stats_letter, stats_value);
      end
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      play_round(1'b1, 2);
      play_round(1'b0, 4);
      finish_game(1'b0, 1'b0, 0, 1'b0, "after_reset");
      #2 reset = 1'b1;
      #1;
      n_vec++;
      if (stats_valid !== 1'b0 || stats_letter !== 4'd0 || stats_value !== 8'd0) begin
         n_err++;
         $display("FAIL reset_in_show_async: valid=%0b letter=%h value=%0d, required 0/0/0", stats_valid, stats_letter, stats_value);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; new_game = 1'b0; round_done = 1'b0; round_ok = 1'b0;
      round_time = '0; game_over = 1'b0;
      model_clear();
      test_reset();
      test_basic();
      test_no_rounds();
      test_same_cycle();
      test_err_sat();
      test_ok_sat();
      test_new_game_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
